marquee_frame_builder: RTL

- Builds the 48-bit, eight-character frame consumed by the 8-digit seven-segment driver.
- Holds a writable message buffer of 6-bit character codes. Either shows the first eight characters statically, or scrolls the whole message right-to-left at a fixed step rate.
- Sits between the game/menu control logic (which writes song titles and scores) and the tube driver's 48-bit input.

---
 rtl/marquee_frame_builder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/marquee_frame_builder.sv
// Builds the eight-character frame for the seven-segment tube driver from a
// writable message buffer, either showing it statically or scrolling it leftward.
module marquee_frame_builder #(
  parameter int         MSG_DEPTH = 32,
  parameter int         TICK_DIV  = 50000000,
  parameter logic [5:0] BLANK     = 6'd20
) (
  input  logic                         sys_clk,
  input  logic                         sys_rest,
  input  logic                         wr_en,
  input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
  input  logic [5:0]                   wr_char,
  input  logic [6:0]                   msg_len,
  input  logic                         mode,
  input  logic                         loop,
  input  logic                         start,
  input  logic                         stop,
  output logic                         busy,
  output logic [47:0]                  frame,
  output logic                         frame_valid,
  output logic                         done
);

  localparam int AW = $clog2(MSG_DEPTH);
  localparam int OW = $clog2(MSG_DEPTH + 9);
  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STATIC = 2'd1;
  localparam logic [1:0] ST_SCROLL = 2'd2;

  localparam logic [47:0] ALL_BLANK = {8{BLANK}};

  logic [5:0]    mem_q [MSG_DEPTH];
  logic [1:0]    state_q, state_d;
  logic [OW-1:0] off_q, off_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [6:0]    len_q, len_d;
  logic          loop_q, loop_d;
  logic [47:0]   frame_q, frame_d;
  logic          fv_q, fv_d;
  logic          done_q, done_d;
  logic [6:0]    lenIn;

  always_ff @(posedge sys_clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_char;
  end

  // Window digit i shows V[off+i]; V is 8 blanks, then the message, then blanks.
  // The index is widened so that out-of-range positions never alias into the buffer.
  function automatic logic [47:0] compose(input logic [OW-1:0] off, input logic [6:0] len);
    logic [SW-1:0] pos;
    logic [47:0]   f;
    f = ALL_BLANK;
    for (int i = 0; i < 8; i++) begin
      pos = SW'(off) + SW'(i);
      if (pos >= SW'(8) && (pos - SW'(8)) < SW'(len))
        f[47-6*i -: 6] = mem_q[AW'(pos - SW'(8))];
    end
    return f;
  endfunction

  assign lenIn = (msg_len > 7'(MSG_DEPTH)) ? 7'(MSG_DEPTH) : msg_len;

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    tick_d  = tick_q;
    len_d   = len_q;
    loop_d  = loop_q;
    frame_d = frame_q;
    fv_d    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop && lenIn != 7'd0) begin
          len_d  = lenIn;
          loop_d = loop;
          off_d  = '0;
          tick_d = '0;
          fv_d   = 1'b1;
          if (mode) begin
            state_d = ST_SCROLL;
            frame_d = ALL_BLANK;
          end else begin
            state_d = ST_STATIC;
            frame_d = compose(OW'(8), lenIn);
          end
        end
      end
      ST_STATIC, ST_SCROLL: begin
        if (stop) begin
          state_d = ST_IDLE;
          frame_d = ALL_BLANK;
          fv_d    = 1'b1;
          off_d   = '0;
          tick_d  = '0;
        end else if (state_q == ST_SCROLL) begin
          if (tick_q == TW'(TICK_DIV - 1)) begin
            tick_d = '0;
            // The all-blank window at off = len+8 is the last frame of a pass.
            if (off_q == OW'(len_q) + OW'(8)) begin
              done_d  = 1'b1;
              off_d   = '0;
              frame_d = ALL_BLANK;
              if (loop_q) fv_d = 1'b1;
              else        state_d = ST_IDLE;
            end else begin
              off_d   = off_q + OW'(1);
              frame_d = compose(off_q + OW'(1), len_q);
              fv_d    = 1'b1;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rest) begin
      state_q <= ST_IDLE;
      off_q   <= '0;
      tick_q  <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      frame_q <= ALL_BLANK;
      fv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      tick_q  <= tick_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
      frame_q <= frame_d;
      fv_q    <= fv_d;
      done_q  <= done_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign frame       = frame_q;
  assign frame_valid = fv_q;
  assign done        = done_q;

endmodule
